// File: rtl/hiscore_pkg.sv
// Shared types and helpers for the hiscore RAM arbiter.
// Holds the arbiter state encoding, the port-mux select values and the
// counter-width helper used to size the down counters.
package hiscore_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        GRANT,
        WRITE,
        READ,
        ACKW,
        RELEASE,
        UNPAUSE
    } hs_arb_state_t;

    localparam logic MUX_CPU = 1'b0;
    localparam logic MUX_HS  = 1'b1;

    // Bits needed to hold 0..max_val. Never returns less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hs_down_counter.sv
// Loadable down counter with a zero flag. Used for the settle/read timer and the hold timer.
// Ports: i_clk/i_reset (sync, active high), i_load + i_load_val (load has priority),
//        i_dec (decrement, saturates at zero), o_zero (count is zero).
module hs_down_counter #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            // Saturate at zero so a stray decrement can never wrap.
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares one game-RAM port between the game CPU and the hiscore engine.
// Pauses the CPU, waits a settle period, switches the RAM mux to the hiscore side, performs
// single-beat reads/writes under a req/ack handshake, then hands the port back before unpausing.
// Ports: i_clk/i_reset (sync, active high); i_cpu_* / o_cpu_din: game CPU side;
//        i_hs_req/i_hs_wr/i_hs_addr/i_hs_wdata, o_hs_ack/o_hs_rdata: hiscore side;
//        o_ram_addr/o_ram_din/o_ram_we, i_ram_dout: game RAM; o_pause halts CPU; o_busy = not idle.
module hiscore_ram_arbiter
    import hiscore_pkg::*;
#(
    parameter int AW            = 10,
    parameter int DW            = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int READ_LAT      = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dout,
    input  logic          i_cpu_we,
    output logic [DW-1:0] o_cpu_din,
    input  logic          i_hs_req,
    input  logic          i_hs_wr,
    input  logic [AW-1:0] i_hs_addr,
    input  logic [DW-1:0] i_hs_wdata,
    output logic          o_hs_ack,
    output logic [DW-1:0] o_hs_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dout,
    output logic          o_pause,
    output logic          o_busy
);

    // One timer serves both the settle wait and the read wait, so size it for the larger.
    localparam int TMR_MAX  = ((SETTLE_CYCLES > READ_LAT) ? SETTLE_CYCLES : READ_LAT) - 1;
    localparam int TMR_W    = cnt_width(TMR_MAX);
    localparam int HOLD_W   = cnt_width(HOLD_CYCLES - 1);

    hs_arb_state_t r_state;
    hs_arb_state_t w_next_state;

    logic          r_pause;
    logic          r_mux_sel;
    logic          r_hs_we;
    logic          r_hs_ack;
    logic [DW-1:0] r_hs_rdata;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_load_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic             w_hold_load;
    logic             w_hold_dec;
    logic             w_hold_zero;

    logic w_pause_set;
    logic w_pause_clr;
    logic w_mux_to_hs;
    logic w_mux_to_cpu;
    logic w_we_set;
    logic w_we_clr;
    logic w_ack_set;
    logic w_capture;

    hs_down_counter #(.W(TMR_W)) u_tmr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    hs_down_counter #(.W(HOLD_W)) u_hold (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_W'(HOLD_CYCLES - 1)),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = TMR_W'(SETTLE_CYCLES - 1);
        w_tmr_dec      = 1'b0;
        w_hold_load    = 1'b0;
        w_hold_dec     = 1'b0;
        w_pause_set    = 1'b0;
        w_pause_clr    = 1'b0;
        w_mux_to_hs    = 1'b0;
        w_mux_to_cpu   = 1'b0;
        w_we_set       = 1'b0;
        w_we_clr       = 1'b0;
        w_ack_set      = 1'b0;
        w_capture      = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_hs_req) begin
                    w_next_state = PAUSE;
                    w_pause_set  = 1'b1;
                    w_tmr_load   = 1'b1;
                end
            end
            PAUSE: begin
                if (w_tmr_zero) begin
                    w_next_state = GRANT;
                    w_mux_to_hs  = 1'b1;
                    w_hold_load  = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            GRANT: begin
                if (i_hs_req) begin
                    // Any request restarts the idle-hold window.
                    w_hold_load = 1'b1;
                    if (i_hs_wr) begin
                        w_next_state = WRITE;
                        w_we_set     = 1'b1;
                    end else begin
                        w_next_state   = READ;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = TMR_W'(READ_LAT - 1);
                    end
                end else if (w_hold_zero) begin
                    w_next_state = RELEASE;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            WRITE: begin
                w_next_state = ACKW;
                w_we_clr     = 1'b1;
                w_ack_set    = 1'b1;
            end
            READ: begin
                // Address has been on the RAM since GRANT; data is valid READ_LAT cycles later.
                if (w_tmr_zero) begin
                    w_next_state = ACKW;
                    w_capture    = 1'b1;
                    w_ack_set    = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ACKW: begin
                w_next_state = GRANT;
                w_hold_load  = 1'b1;
            end
            RELEASE: begin
                // Mux returns to the CPU while pause is still high.
                w_next_state = UNPAUSE;
                w_mux_to_cpu = 1'b1;
            end
            UNPAUSE: begin
                w_next_state = IDLE;
                w_pause_clr  = 1'b1;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pause    <= 1'b0;
            r_mux_sel  <= MUX_CPU;
            r_hs_we    <= 1'b0;
            r_hs_ack   <= 1'b0;
            r_hs_rdata <= '0;
        end else begin
            r_hs_ack <= w_ack_set;
            if (w_pause_set) begin
                r_pause <= 1'b1;
            end else if (w_pause_clr) begin
                r_pause <= 1'b0;
            end
            if (w_mux_to_hs) begin
                r_mux_sel <= MUX_HS;
            end else if (w_mux_to_cpu) begin
                r_mux_sel <= MUX_CPU;
            end
            if (w_we_set) begin
                r_hs_we <= 1'b1;
            end else if (w_we_clr) begin
                r_hs_we <= 1'b0;
            end
            if (w_capture) begin
                r_hs_rdata <= i_ram_dout;
            end
        end
    end

    // RAM port mux. CPU writes are dropped entirely while the hiscore side owns the port.
    always_comb begin
        if (r_mux_sel == MUX_HS) begin
            o_ram_addr = i_hs_addr;
            o_ram_din  = i_hs_wdata;
            o_ram_we   = r_hs_we;
        end else begin
            o_ram_addr = i_cpu_addr;
            o_ram_din  = i_cpu_dout;
            o_ram_we   = i_cpu_we;
        end
    end

    assign o_cpu_din  = i_ram_dout;
    assign o_hs_ack   = r_hs_ack;
    assign o_hs_rdata = r_hs_rdata;
    assign o_pause    = r_pause;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
module tb_hiscore_ram_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int SETTLE = 4;
    localparam int HOLD   = 16;
    localparam int RL     = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic          cpu_we;
    logic [DW-1:0] cpu_din;
    logic          hs_req;
    logic          hs_wr;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_ack;
    logic [DW-1:0] hs_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          pause;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .READ_LAT(RL)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cpu_addr (cpu_addr),
        .i_cpu_dout (cpu_dout),
        .i_cpu_we   (cpu_we),
        .o_cpu_din  (cpu_din),
        .i_hs_req   (hs_req),
        .i_hs_wr    (hs_wr),
        .i_hs_addr  (hs_addr),
        .i_hs_wdata (hs_wdata),
        .o_hs_ack   (hs_ack),
        .o_hs_rdata (hs_rdata),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .o_ram_we   (ram_we),
        .i_ram_dout (ram_dout),
        .o_pause    (pause),
        .o_busy     (busy)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 10'h040) return 8'h3C;
        return a[7:0] ^ 8'h5A ^ {6'd0, a[9:8]};
    endfunction

    // Game RAM: synchronous write, RL-cycle read pipeline, reloaded on reset.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] rd_pipe [0:RL-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(AW'(i));
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RL-1];

    // Reference contents of the RAM as the hiscore engine should see them.
    logic [DW-1:0] ref_mem [0:1023];
    logic          pause_hist [0:255];
    int            since;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int g);
        repeat (g) step();
        since += g;
    endtask

    // Cycle (relative to raising hs_req) on which hs_ack is expected, given how many
    // cycles have passed since the previous ack (g < 0: arbiter known idle).
    // After an ack: GRANT for HOLD idle cycles, then RELEASE, UNPAUSE, IDLE.
    function automatic int exp_latency(input bit wr, input int g);
        int svc;
        int from_idle;
        svc       = wr ? 1 : RL;
        from_idle = SETTLE + 2 + svc;
        if (g < 0 || g >= HOLD + 3) return from_idle;
        if (g == 0)                 return 2 + svc;
        if (g <= HOLD)              return 1 + svc;
        if (g == HOLD + 1)          return 2 + from_idle;
        return 1 + from_idle;
    endfunction

    task automatic hs_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int exp_lat, input string tag);
        int n;
        int we_cnt;
        int we_cyc;
        int grant_cyc;
        bit got;
        grant_cyc = exp_lat - (wr ? 2 : RL + 1);
        hs_req   = 1'b1;
        hs_wr    = wr;
        hs_addr  = a;
        hs_wdata = d;
        n = 0; we_cnt = 0; we_cyc = -1; got = 1'b0;
        pause_hist[0] = pause;
        while (!got && n < 200) begin
            step();
            n++;
            pause_hist[n] = pause;
            // Once the hiscore side owns the port, CPU write attempts must be ignored.
            if (n >= grant_cyc) begin
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom);
                cpu_dout = DW'($urandom);
            end else begin
                cpu_we = 1'b0;
            end
            #1;
            if (ram_we) begin
                we_cnt++;
                we_cyc = n;
                chk({tag, " ram_addr"}, 32'(ram_addr), 32'(a));
                chk({tag, " ram_din"}, 32'(ram_din), 32'(d));
            end
            if (hs_ack) got = 1'b1;
        end
        cpu_we = 1'b0;
        chk({tag, " ack cycle"}, n, exp_lat);
        if (wr) begin
            chk({tag, " we pulses"}, we_cnt, 1);
            chk({tag, " we cycle"}, we_cyc, exp_lat - 1);
            ref_mem[a] = d;
        end else begin
            chk({tag, " we pulses"}, we_cnt, 0);
            chk({tag, " rdata"}, 32'(hs_rdata), 32'(ref_mem[a]));
        end
        hs_req = 1'b0;
        since  = 0;
    endtask

    initial begin
        int mux_k;
        int p_k;
        int acks;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            g;

        reset = 1'b1; hs_req = 1'b0; hs_wr = 1'b0; hs_addr = '0; hs_wdata = '0;
        cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
        since = -1;
        repeat (3) step();
        reset = 1'b0;

        chk("reset pause", 32'(pause), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset hs_ack", 32'(hs_ack), 0);
        chk("reset hs_rdata", 32'(hs_rdata), 0);
        chk("reset ram_we", 32'(ram_we), 0);

        // CPU owns the port while idle.
        cpu_we = 1'b1; cpu_addr = 10'h010; cpu_dout = 8'h77;
        #1;
        chk("idle cpu we", 32'(ram_we), 1);
        chk("idle cpu addr", 32'(ram_addr), 32'h010);
        chk("idle cpu din", 32'(ram_din), 32'h77);
        ref_mem[10'h010] = 8'h77;
        step();
        cpu_we = 1'b0;

        // Write from idle.
        hs_access(1'b1, 10'h123, 8'hA5, exp_latency(1'b1, -1), "T2");
        chk("T2 pause before", 32'(pause_hist[0]), 0);
        chk("T2 pause at +1", 32'(pause_hist[1]), 1);

        // Read from idle.
        idle_cycles(HOLD + 3);
        chk("idle after release busy", 32'(busy), 0);
        hs_access(1'b0, 10'h040, 8'h00, exp_latency(1'b0, since), "T3");
        chk("T3 rdata 3C", 32'(hs_rdata), 32'h3C);
        idle_cycles(3);
        chk("T3 rdata held", 32'(hs_rdata), 32'h3C);

        // Burst of writes then release.
        idle_cycles(HOLD);
        for (int i = 0; i < 8; i++) begin
            hs_access(1'b1, AW'(i), DW'($urandom), exp_latency(1'b1, since), "T4 burst");
        end
        cpu_addr = 10'h3F0;
        mux_k = -1; p_k = -1;
        for (int k = 1; k <= HOLD + 6; k++) begin
            step();
            if (mux_k < 0 && ram_addr == cpu_addr) mux_k = k;
            if (p_k < 0 && !pause) p_k = k;
        end
        since = HOLD + 6;
        chk("T4 mux back to cpu", mux_k, HOLD + 2);
        chk("T4 pause low", p_k, HOLD + 3);
        chk("T4 idle busy", 32'(busy), 0);

        // Request arriving in the RELEASE cycle.
        hs_access(1'b1, 10'h200, 8'h5A, exp_latency(1'b1, since), "T5 pre");
        idle_cycles(HOLD + 1);
        hs_access(1'b1, 10'h201, 8'hC3, exp_latency(1'b1, since), "T5");
        chk("T5 pause in unpause", 32'(pause_hist[1]), 1);
        chk("T5 pause low gap", 32'(pause_hist[2]), 0);
        chk("T5 pause re-asserted", 32'(pause_hist[3]), 1);

        // Randomised accesses with random gaps covering every arbiter phase.
        for (int t = 0; t < 30; t++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 63));
            d = DW'($urandom);
            g = $urandom_range(0, HOLD + 6);
            idle_cycles(g);
            hs_access(w, a, d, exp_latency(w, since), "rand");
        end

        // Reset in the middle of a read aborts it.
        idle_cycles(HOLD + 3);
        cpu_addr = 10'h2AA;
        hs_req = 1'b1; hs_wr = 1'b0; hs_addr = 10'h055;
        repeat (SETTLE + 2) step();
        chk("T1 busy in read", 32'(busy), 1);
        chk("T1 pause in read", 32'(pause), 1);
        reset  = 1'b1;
        hs_req = 1'b0;
        step();
        chk("T1 pause after reset", 32'(pause), 0);
        chk("T1 busy after reset", 32'(busy), 0);
        chk("T1 hs_ack after reset", 32'(hs_ack), 0);
        chk("T1 ram_we after reset", 32'(ram_we), 0);
        chk("T1 mux cpu after reset", 32'(ram_addr), 32'h2AA);
        reset = 1'b0;
        acks = 0;
        repeat (6) begin
            step();
            if (hs_ack) acks++;
        end
        chk("T1 no late ack", acks, 0);
        chk("T1 rdata cleared", 32'(hs_rdata), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
